// File: rtl/theremin_i2c_pkg.sv
// Shared types and default device bytes for the theremin I2C target.
// The write/read device bytes differ only in the R/W bit of the address byte.
package theremin_i2c_pkg;

    localparam logic [7:0] DEFAULT_WR_ID = 8'h34;
    localparam logic [7:0] DEFAULT_RD_ID = 8'h35;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        REG,
        REG_ACK,
        DATA_W,
        DATA_R,
        DATA_ACK,
        WAIT_STOP
    } i2c_tgt_state_t;

endpackage

// File: rtl/theremin_i2c_target_if.sv
// One-byte register bus between the I2C target (master side) and the
// FPGA control-register bank (slave side).
interface theremin_i2c_target_if;

    logic [7:0] REG_ADDR;
    logic [7:0] REG_WDATA;
    logic       REG_WE;
    logic       REG_RD;
    logic [7:0] REG_RDATA;

    modport master (
        output REG_ADDR,
        output REG_WDATA,
        output REG_WE,
        output REG_RD,
        input  REG_RDATA
    );

    modport slave (
        input  REG_ADDR,
        input  REG_WDATA,
        input  REG_WE,
        input  REG_RD,
        output REG_RDATA
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stability filter for one raw I2C pin.
// The filtered level only follows the pin after FILTER_LEN stable cycles.
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic [3:0] stable_cnt;

    // rise/fall pulse in the same cycle the new level becomes visible
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync       <= 2'b11;
            level      <= 1'b1;
            stable_cnt <= 4'd0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                stable_cnt <= 4'd0;
            end else if (stable_cnt == 4'(FILTER_LEN - 1)) begin
                level      <= sync[1];
                rise       <= sync[1];
                fall       <= ~sync[1];
                stable_cnt <= 4'd0;
            end else begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/theremin_i2c_target.sv
// I2C target for the theremin's three-byte frames (device, register, data),
// mapping each frame onto a single register-bus write or read.
module theremin_i2c_target
    import theremin_i2c_pkg::*;
#(
    parameter logic [7:0] WR_ID      = DEFAULT_WR_ID,
    parameter logic [7:0] RD_ID      = DEFAULT_RD_ID,
    parameter int         FILTER_LEN = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         SCL_IN,
    input  logic                         SDA_IN,
    output logic                         SDA_OE,
    output logic                         BUSY,
    theremin_i2c_target_if.master        bus
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_evt, stop_evt;

    i2c_tgt_state_t state, state_next;
    logic [7:0] shift, shift_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic       byte_done, byte_done_next;
    logic       read_flag, read_flag_next;
    logic       sda_oe, sda_oe_next;
    logic [7:0] reg_addr, reg_addr_next;
    logic [7:0] reg_wdata, reg_wdata_next;
    logic       reg_we, reg_we_next;
    logic       reg_rd, reg_rd_next;
    logic [7:0] rx_byte;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .CLK   (CLK),
        .RESET (RESET),
        .pin   (SCL_IN),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .CLK   (CLK),
        .RESET (RESET),
        .pin   (SDA_IN),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_evt = sda_fall & scl_level;
    assign stop_evt  = sda_rise & scl_level;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            read_flag <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_rd    <= 1'b0;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            bit_cnt   <= bit_cnt_next;
            byte_done <= byte_done_next;
            read_flag <= read_flag_next;
            sda_oe    <= sda_oe_next;
            reg_addr  <= reg_addr_next;
            reg_wdata <= reg_wdata_next;
            reg_we    <= reg_we_next;
            reg_rd    <= reg_rd_next;
        end
    end

    // START/STOP are checked before any SCL edge so they win a same-cycle tie
    always_comb begin
        state_next     = state;
        shift_next     = shift;
        bit_cnt_next   = bit_cnt;
        byte_done_next = byte_done;
        read_flag_next = read_flag;
        sda_oe_next    = sda_oe;
        reg_addr_next  = reg_addr;
        reg_wdata_next = reg_wdata;
        reg_we_next    = 1'b0;
        reg_rd_next    = 1'b0;
        rx_byte        = {shift[6:0], sda_level};

        if (stop_evt) begin
            state_next     = IDLE;
            sda_oe_next    = 1'b0;
            bit_cnt_next   = 3'd0;
            byte_done_next = 1'b0;
        end else if (start_evt) begin
            state_next     = DEV;
            sda_oe_next    = 1'b0;
            bit_cnt_next   = 3'd0;
            byte_done_next = 1'b0;
        end else begin
            case (state)
                DEV, REG, DATA_W: begin
                    if (scl_rise && !byte_done) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done_next = 1'b1;
                            if (state == DATA_W) begin
                                reg_wdata_next = rx_byte;
                                reg_we_next    = 1'b1;
                            end
                        end
                    end else if (scl_fall && byte_done) begin
                        byte_done_next = 1'b0;
                        if (state == DEV) begin
                            if (shift == WR_ID || shift == RD_ID) begin
                                read_flag_next = (shift == RD_ID);
                                state_next     = DEV_ACK;
                                sda_oe_next    = 1'b1;
                            end else begin
                                state_next = WAIT_STOP;
                            end
                        end else if (state == REG) begin
                            reg_addr_next = shift;
                            reg_rd_next   = read_flag;
                            state_next    = REG_ACK;
                            sda_oe_next   = 1'b1;
                        end else begin
                            state_next  = DATA_ACK;
                            sda_oe_next = 1'b1;
                        end
                    end
                end
                DEV_ACK: begin
                    if (scl_fall) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = 3'd0;
                        state_next   = REG;
                    end
                end
                REG_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = 3'd0;
                        if (read_flag) begin
                            shift_next  = bus.REG_RDATA;
                            sda_oe_next = ~bus.REG_RDATA[7];
                            state_next  = DATA_R;
                        end else begin
                            sda_oe_next = 1'b0;
                            state_next  = DATA_W;
                        end
                    end
                end
                DATA_R: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_next = 1'b1;
                            state_next  = DATA_ACK;
                        end else begin
                            shift_next   = {shift[6:0], 1'b0};
                            sda_oe_next  = ~shift[6];
                            bit_cnt_next = bit_cnt + 3'd1;
                        end
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_next = 1'b0;
                        state_next  = WAIT_STOP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign SDA_OE        = sda_oe;
    assign BUSY          = (state != IDLE);
    assign bus.REG_ADDR  = reg_addr;
    assign bus.REG_WDATA = reg_wdata;
    assign bus.REG_WE    = reg_we;
    assign bus.REG_RD    = reg_rd;

endmodule

// File: tb/tb_theremin_i2c_target.sv
// Bench for theremin_i2c_target: an open-drain I2C controller model drives
// whole frames and compares each against transaction-level expectations.
module tb_theremin_i2c_target;

    logic CLK = 1'b0;
    logic RESET;
    logic scl_drv;
    logic sda_drv;
    logic SDA_OE;
    logic BUSY;
    logic [7:0] rdata_value;
    wire  sda_line = sda_drv & ~SDA_OE;

    int quarter = 16;
    int tests_run = 0;
    int tests_failed = 0;

    int we_cycles = 0;
    int rd_cycles = 0;
    int oe_cycles = 0;
    logic [7:0] we_addr, we_data, rd_addr;

    theremin_i2c_target_if bus();

    assign bus.REG_RDATA = rdata_value;

    theremin_i2c_target #(
        .WR_ID      (8'h34),
        .RD_ID      (8'h35),
        .FILTER_LEN (4)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .SCL_IN (scl_drv),
        .SDA_IN (sda_line),
        .SDA_OE (SDA_OE),
        .BUSY   (BUSY),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    // Strobe cycles and target drive time, accumulated; frames look at deltas
    always @(negedge CLK) begin
        if (bus.REG_WE) begin
            we_cycles = we_cycles + 1;
            we_addr   = bus.REG_ADDR;
            we_data   = bus.REG_WDATA;
        end
        if (bus.REG_RD) begin
            rd_cycles = rd_cycles + 1;
            rd_addr   = bus.REG_ADDR;
        end
        if (SDA_OE) oe_cycles = oe_cycles + 1;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run = tests_run + 1;
        if (observed !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1;
        wait_clk(quarter);
        scl_drv = 1'b1;
        wait_clk(quarter);
        sda_drv = 1'b0;
        wait_clk(quarter);
        scl_drv = 1'b0;
        wait_clk(quarter);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0;
        wait_clk(quarter);
        scl_drv = 1'b1;
        wait_clk(quarter);
        sda_drv = 1'b1;
        wait_clk(quarter);
    endtask

    // glitch 1: short SCL pulse while low; glitch 2: short SDA flip while SCL high
    task automatic bus_bit(input logic bit_out, input int glitch, output logic bit_in);
        sda_drv = bit_out;
        if (glitch == 1) begin
            wait_clk(4);
            scl_drv = 1'b1;
            wait_clk(2);
            scl_drv = 1'b0;
            wait_clk(quarter - 6);
        end else begin
            wait_clk(quarter);
        end
        scl_drv = 1'b1;
        wait_clk(quarter);
        bit_in = sda_line;
        if (glitch == 2) begin
            sda_drv = ~bit_out;
            wait_clk(2);
            sda_drv = bit_out;
            wait_clk(quarter - 2);
        end else begin
            wait_clk(quarter);
        end
        scl_drv = 1'b0;
        wait_clk(quarter);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch, input int gidx, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(b[i], (i == gidx) ? glitch : 0, dummy);
        end
        bus_bit(1'b1, 0, ack);
    endtask

    task automatic read_byte(output logic [7:0] b, output logic ack);
        logic bit_in;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 0, bit_in);
            b[i] = bit_in;
        end
        bus_bit(1'b1, 0, ack);
    endtask

    // One complete frame, judged only by what an I2C frame of this kind must do
    task automatic applyStimulus(input logic [7:0] dev, input logic [7:0] addr,
                                 input logic [7:0] data, input int glitch);
        int we0, rd0, oe0, gidx;
        logic ack_dev, ack_reg, ack_data, known, is_read, is_write;
        logic [7:0] rx;
        we0      = we_cycles;
        rd0      = rd_cycles;
        oe0      = oe_cycles;
        known    = (dev == 8'h34) || (dev == 8'h35);
        is_read  = (dev == 8'h35);
        is_write = (dev == 8'h34);
        gidx     = (glitch == 1) ? 3 : 5;
        rx       = 8'h00;
        if (is_read) rdata_value = data;

        bus_start();
        checkOutput("busy_in_frame", 32'(BUSY), 32'(1));
        write_byte(dev, 0, 0, ack_dev);
        write_byte(addr, 0, 0, ack_reg);
        if (is_read) read_byte(rx, ack_data);
        else         write_byte(data, glitch, gidx, ack_data);
        bus_stop();

        checkOutput("ack_dev", 32'(ack_dev), 32'(!known));
        checkOutput("ack_reg", 32'(ack_reg), 32'(!known));
        checkOutput("ack_data", 32'(ack_data), 32'(!known));
        checkOutput("we_pulses", 32'(we_cycles - we0), 32'(is_write));
        checkOutput("rd_pulses", 32'(rd_cycles - rd0), 32'(is_read));
        if (is_write) begin
            checkOutput("we_addr", 32'(we_addr), 32'(addr));
            checkOutput("we_data", 32'(we_data), 32'(data));
        end
        if (is_read) begin
            checkOutput("rd_addr", 32'(rd_addr), 32'(addr));
            checkOutput("rd_byte", 32'(rx), 32'(data));
        end
        if (!known) checkOutput("oe_silent", 32'(oe_cycles - oe0), 32'(0));
        checkOutput("busy_after_stop", 32'(BUSY), 32'(0));
    endtask

    initial begin
        logic a0, a1, a2, a3, a4, dummy;
        logic [7:0] dev;
        int we0, rd0, kind;

        RESET       = 1'b1;
        scl_drv     = 1'b1;
        sda_drv     = 1'b1;
        rdata_value = 8'h00;
        wait_clk(5);
        checkOutput("rst_sda_oe", 32'(SDA_OE), 32'(0));
        checkOutput("rst_busy", 32'(BUSY), 32'(0));
        checkOutput("rst_reg_addr", 32'(bus.REG_ADDR), 32'(0));
        checkOutput("rst_reg_wdata", 32'(bus.REG_WDATA), 32'(0));
        checkOutput("rst_strobes", 32'({bus.REG_WE, bus.REG_RD}), 32'(0));
        RESET = 1'b0;
        wait_clk(10);

        // 400 kHz write, then faster bus for everything else
        quarter = 62;
        applyStimulus(8'h34, 8'h05, 8'hA7, 0);
        quarter = 16;
        applyStimulus(8'h35, 8'h12, 8'h5C, 0);
        applyStimulus(8'h40, 8'h22, 8'h33, 0);
        applyStimulus(8'h34, 8'h3C, 8'h96, 1);
        applyStimulus(8'h34, 8'h3D, 8'h6B, 2);

        // Repeated START after the register byte
        we0 = we_cycles;
        rd0 = rd_cycles;
        bus_start();
        write_byte(8'h34, 0, 0, a0);
        write_byte(8'h07, 0, 0, a1);
        bus_start();
        write_byte(8'h34, 0, 0, a2);
        write_byte(8'h01, 0, 0, a3);
        write_byte(8'hFF, 0, 0, a4);
        bus_stop();
        checkOutput("rs_acks", 32'({a0, a1, a2, a3, a4}), 32'(0));
        checkOutput("rs_we_pulses", 32'(we_cycles - we0), 32'(1));
        checkOutput("rs_rd_pulses", 32'(rd_cycles - rd0), 32'(0));
        checkOutput("rs_we_addr", 32'(we_addr), 32'(8'h01));
        checkOutput("rs_we_data", 32'(we_data), 32'(8'hFF));

        // RESET while the target is driving a zero data bit
        we0 = we_cycles;
        rd0 = rd_cycles;
        rdata_value = 8'h00;
        bus_start();
        write_byte(8'h35, 0, 0, a0);
        write_byte(8'h20, 0, 0, a1);
        bus_bit(1'b1, 0, dummy);
        bus_bit(1'b1, 0, dummy);
        checkOutput("rr_oe_before", 32'(SDA_OE), 32'(1));
        RESET = 1'b1;
        wait_clk(1);
        checkOutput("rr_oe_after", 32'(SDA_OE), 32'(0));
        checkOutput("rr_busy_after", 32'(BUSY), 32'(0));
        RESET = 1'b0;
        wait_clk(quarter);
        scl_drv = 1'b1;
        wait_clk(2 * quarter);
        checkOutput("rr_we_pulses", 32'(we_cycles - we0), 32'(0));
        checkOutput("rr_rd_pulses", 32'(rd_cycles - rd0), 32'(1));
        applyStimulus(8'h34, 8'h44, 8'h5A, 0);

        for (int t = 0; t < 12; t++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0)      dev = 8'h34;
            else if (kind == 1) dev = 8'h35;
            else begin
                dev = 8'($urandom_range(0, 255));
                if (dev == 8'h34 || dev == 8'h35) dev = 8'h36;
            end
            applyStimulus(dev, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/theremin_i2c_target.md
# theremin_i2c_target

I2C responder (target) for the three-byte framing used by the theremin I2C controller: device byte, register byte, then one data byte written by the controller or returned by the target. It samples raw SCL/SDA pins with CLK, filters them, and maps each transaction onto a simple one-byte register bus. It exposes a bank of FPGA-side control registers to an external I2C controller, and serves as the loopback target for controller verification. IOBUF/open-drain pads stay in the top-level wrapper.

## Interface
- WR_ID, 8'h34: device byte that selects a write transaction.
- RD_ID, 8'h35: device byte that selects a read transaction.
- FILTER_LEN, 4: CLK cycles a synchronized line must stay stable before its filtered value changes; range 1..15.
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  synchronous, active-high reset.
- SCL_IN  in  1  raw SCL pin level; asynchronous.
- SDA_IN  in  1  raw SDA pin level; asynchronous.
- SDA_OE  out  1  1 = pull SDA low, 0 = release. Reset 0.
- REG_ADDR  out  8  register byte of the current transaction. Reset 0.
- REG_WDATA  out  8  write data; valid while REG_WE=1. Reset 0.
- REG_WE  out  1  one-cycle write strobe. Reset 0.
- REG_RD  out  1  one-cycle read request; REG_ADDR is valid. Reset 0.
- REG_RDATA  in  8  read data; must be valid within 64 CLK after REG_RD and held until the next REG_RD.
- BUSY  out  1  high while not IDLE. Reset 0.

## Operation
- Each line goes through a 2-flop synchronizer and then a stability filter. The filtered value initializes to 1 on reset.
- Events are derived from the filtered signals:
  - scl_rise, scl_fall: edges of filtered SCL.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- States: IDLE, DEV, DEV_ACK, REG, REG_ACK, DATA_W, DATA_R, DATA_ACK, WAIT_STOP.
- Data bits: MSB first, sampled on scl_rise into an 8-bit shift register; a 3-bit counter tracks bit position.
- DEV: at the scl_fall following the 8th bit:
  - byte = WR_ID or RD_ID: latch a read flag, enter DEV_ACK, assert SDA_OE.
  - otherwise: enter WAIT_STOP with SDA released.
- DEV_ACK: the next scl_fall releases SDA_OE and enters REG.
- REG: at the scl_fall following the 8th bit:
  - REG_ADDR <= byte; enter REG_ACK; SDA_OE=1.
  - If the read flag is set, pulse REG_RD in the same cycle.
- REG_ACK: at the next scl_fall:
  - write: release SDA, enter DATA_W.
  - read: load REG_RDATA into the shift register, drive SDA_OE = ~bit7, enter DATA_R.
- DATA_W: after the 8th bit's scl_rise, REG_WDATA <= byte and REG_WE pulses the following cycle. At the next scl_fall, enter DATA_ACK with SDA_OE=1.
- DATA_R: at each scl_fall, shift and drive the next bit. After the 8th bit's scl_fall, enter DATA_ACK with SDA_OE=1.
- DATA_ACK: the target drives ACK=0 in both modes, because the controller checks this slot. The next scl_fall releases SDA and enters WAIT_STOP.
- No auto-increment: further bytes are ignored in WAIT_STOP with SDA released.
- START in any state: clear the bit counter, enter DEV, SDA_OE=0. This covers repeated START.
- STOP in any state: enter IDLE, SDA_OE=0.
- RESET mid-transaction: IDLE, all outputs at reset values, no strobe issued.

## Timing
- Each filtered edge trails its pin edge by 2+FILTER_LEN CLK; SDA_OE changes 1 CLK after the detected scl_fall. This gives ≥6 CLK of SDA hold at 100 MHz.
- A pin glitch shorter than FILTER_LEN CLK produces no event.
- If START/STOP and an SCL edge are detected in the same cycle, START/STOP wins.
- REG_WE and REG_RD are exactly 1 CLK wide, at most one of each per transaction.

## Structure
- `theremin_i2c_pkg` holds the state enum `i2c_tgt_state_t` and the default WR_ID/RD_ID constants.
- Sub-module `i2c_line_filter` (synchronizer + stability counter + rise/fall pulses) is instantiated once for SCL and once for SDA.

## Test plan
- Write: START, 0x34, 0x05, 0xA7, STOP at a 400 kHz bus → ACK low in all three slots; one REG_WE pulse with REG_ADDR=0x05, REG_WDATA=0xA7; BUSY returns to 0 after STOP.
- Read: START, 0x35, 0x12, then clock 8 bits with REG_RDATA=0x5C → one REG_RD pulse with REG_ADDR=0x12; SDA reads 0x5C MSB first; ACK driven low; no REG_WE.
- Wrong device: START, 0x40, … → SDA_OE stays 0 for the whole frame; no strobes.
- Repeated START after the register byte, then a full write of 0x34/0x01/0xFF → only that write strobes, with REG_ADDR=0x01.
- Glitches: a 2-CLK pulse on SCL with FILTER_LEN=4 → no bit shifted, no state change.
- RESET asserted during DATA_R → SDA_OE=0 next cycle, IDLE, a following valid write completes normally.
